// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian program stream, writes it into
// instruction memory and then releases the CPU. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR0  = 3'd1,
      HDR1  = 3'd2,
      LOAD  = 3'd3,
      WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM  = 3'd5,
`endif
      DONE  = 3'd6,
      ERR   = 3'd7
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CSUM;
`else
   localparam state_t END_STATE = DONE;
`endif

   localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_reg, state_next;
   logic                byte_ready_reg, ready_next;
   logic                imem_we_reg;
   logic [ADDR_W-1:0]   imem_addr_reg;
   logic [31:0]         imem_wdata_reg;
   logic                cpu_rst_reg, busy_reg, done_reg, err_reg;
   logic [ADDR_W:0]     word_count_reg, count_inc;
   logic [15:0]         length_reg, length_hdr;
   logic [1:0]          byte_idx_reg;
   logic [23:0]         word_reg;
   logic                accept;
   logic                len_over;
   logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_reg;
`endif

   assign byte_ready = byte_ready_reg;
   assign imem_we    = imem_we_reg;
   assign imem_addr  = imem_addr_reg;
   assign imem_wdata = imem_wdata_reg;
   assign cpu_rst    = cpu_rst_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;
   assign word_count = word_count_reg;

   assign accept     = byte_valid & byte_ready_reg;
   assign length_hdr = {byte_data, length_reg[7:0]};
   assign len_over   = {16'd0, length_hdr} > 32'(CAPACITY);
   // The count never passes capacity, so a full memory still terminates cleanly.
   assign count_inc  = (word_count_reg == CAPACITY) ? word_count_reg : word_count_reg + COUNT_ONE;
   assign last_word  = 32'(count_inc) == {16'd0, length_reg};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE, ERR: begin
            if (start) state_next = HDR0;
         end
         HDR0: begin
            if (accept) state_next = HDR1;
         end
         HDR1: begin
            if (accept) begin
               if (length_hdr == 16'd0) state_next = END_STATE;
               else if (len_over)       state_next = ERR;
               else                     state_next = LOAD;
            end
         end
         LOAD: begin
            if (accept && byte_idx_reg == 2'd3) state_next = WRITE;
         end
         WRITE: begin
            state_next = last_word ? END_STATE : LOAD;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) state_next = (byte_data == csum_reg) ? DONE : ERR;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_next = (state_next == HDR0) || (state_next == HDR1) || (state_next == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_next == CSUM) ready_next = 1'b1;
`endif
   end

   // Status outputs are registered from the next state so they change with the state itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         byte_ready_reg <= 1'b0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         cpu_rst_reg    <= 1'b1;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         word_count_reg <= '0;
         length_reg     <= '0;
         byte_idx_reg   <= '0;
         word_reg       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_reg       <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         byte_ready_reg <= ready_next;
         imem_we_reg    <= (state_next == WRITE);
         cpu_rst_reg    <= (state_next != DONE);
         done_reg       <= (state_next == DONE);
         err_reg        <= (state_next == ERR);
         busy_reg       <= !((state_next == IDLE) || (state_next == DONE) || (state_next == ERR));

         case (state_reg)
            IDLE, DONE, ERR: begin
               if (start) begin
                  word_count_reg <= '0;
                  byte_idx_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg       <= '0;
`endif
               end
            end
            HDR0: begin
               if (accept) length_reg[7:0] <= byte_data;
            end
            HDR1: begin
               if (accept) length_reg[15:8] <= byte_data;
            end
            LOAD: begin
               if (accept) begin
                  word_reg     <= {byte_data, word_reg[23:8]};
                  byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg     <= csum_reg ^ byte_data;
`endif
                  if (byte_idx_reg == 2'd3) begin
                     imem_addr_reg  <= word_count_reg[ADDR_W-1:0];
                     imem_wdata_reg <= {byte_data, word_reg};
                  end
               end
            end
            WRITE: begin
               word_count_reg <= count_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
